// File: rtl/gpio_pkg.sv
// Shared GPIO constants and helpers for the debounced general-purpose inputs.
package gpio_pkg;

    localparam int GPI_WIDTH            = 4;
    localparam int GPI_DEBOUNCE_DEFAULT = 480000;

    // Counter width able to hold DEBOUNCE_CYCLES-1; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit two-flop synchroniser, stability counter and stable register.
// Edge pulses are built only when GPI_DEBOUNCE_EDGE_EN is defined; otherwise tied to 0.
module debounce_bit
    import gpio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = GPI_DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int             CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flip;

    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        flip     = 1'b0;
        // Any sample matching the stable level leaves cnt_d at zero, so bounces restart the window.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
                flip     = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level = stable_q;

`ifdef GPI_DEBOUNCE_EDGE_EN
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    always_comb begin
        rise_d = flip & sync2_q;
        fall_d = flip & ~sync2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    logic unused_flip;
    assign unused_flip = flip;
    assign rise        = 1'b0;
    assign fall        = 1'b0;
`endif

endmodule

// File: rtl/gpi_debounce.sv
// Debounced, synchronised general-purpose inputs: one debounce_bit per pin.
// Edge pulse outputs are live only when GPI_DEBOUNCE_EDGE_EN is defined.
module gpi_debounce
    import gpio_pkg::*;
#(
    parameter int WIDTH           = GPI_WIDTH,
    parameter int DEBOUNCE_CYCLES = GPI_DEBOUNCE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gpi_raw,
    output logic [WIDTH-1:0] gpi_out,
    output logic [WIDTH-1:0] gpi_rise,
    output logic [WIDTH-1:0] gpi_fall,
    output logic             gpi_changed
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk  (clk),
            .rst  (rst),
            .raw  (gpi_raw[i]),
            .level(gpi_out[i]),
            .rise (gpi_rise[i]),
            .fall (gpi_fall[i])
        );
    end

    assign gpi_changed = |{gpi_rise, gpi_fall};

endmodule

// File: tb/tb_gpi_debounce.sv
// Scoreboard bench for gpi_debounce (WIDTH=4, DEBOUNCE_CYCLES=8) against a sliding-window reference.
module tb_gpi_debounce;

    localparam int W = 4;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] gpi_raw = '0;
    logic [W-1:0] gpi_out, gpi_rise, gpi_fall;
    logic         gpi_changed;

    always #5 clk = ~clk;

    gpi_debounce #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .gpi_raw    (gpi_raw),
        .gpi_out    (gpi_out),
        .gpi_rise   (gpi_rise),
        .gpi_fall   (gpi_fall),
        .gpi_changed(gpi_changed)
    );

    typedef struct packed {
        logic [W-1:0] lvl;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         chg;
    } exp_t;

    exp_t         exp_q[$];
    int           total = 0;
    int           bad   = 0;
    bit           armed = 1'b0;

    // Reference state: full history of pin samples and reset per edge (edge n is index n-1).
    bit [W-1:0]   raw_h[$];
    bit           rst_h[$];
    bit [W-1:0]   m_lvl = '0;
    int           last_evt[W];

    // Pin level the logic sees at edge k: the pin as sampled two edges earlier,
    // forced low if either of those two edges was a reset edge.
    function automatic bit seen_at(input int k, input int b);
        if (k - 2 < 1) return 1'b0;
        if (rst_h[k-3] || rst_h[k-2]) return 1'b0;
        return raw_h[k-3][b];
    endfunction

    // Output toggles at edge n when the last D seen levels, all after the last
    // toggle/reset, disagree with the current output.
    function automatic void model_edge();
        int   n;
        bit   flip;
        exp_t e;
        raw_h.push_back(gpi_raw);
        rst_h.push_back(rst);
        n = raw_h.size();
        e = '0;
        if (rst) begin
            m_lvl = '0;
            for (int b = 0; b < W; b++) last_evt[b] = n;
        end else begin
            for (int b = 0; b < W; b++) begin
                flip = (n - D + 1 > last_evt[b]);
                for (int k = n - D + 1; flip && k <= n; k++)
                    if (seen_at(k, b) == m_lvl[b]) flip = 1'b0;
                if (flip) begin
                    e.rise[b]   = ~m_lvl[b];
                    e.fall[b]   = m_lvl[b];
                    m_lvl[b]    = ~m_lvl[b];
                    last_evt[b] = n;
                end
            end
        end
        e.lvl = m_lvl;
`ifdef GPI_DEBOUNCE_EDGE_EN
        e.chg = |(e.rise | e.fall);
`else
        e.rise = '0;
        e.fall = '0;
        e.chg  = 1'b0;
`endif
        exp_q.push_back(e);
        armed = 1'b1;
    endfunction

    task automatic drive(input logic r, input logic [W-1:0] v, input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            rst     = r;
            gpi_raw = v;
            @(posedge clk);
            model_edge();
        end
    endtask

    // Monitor: one expected entry per edge, checked 2 time units after the edge.
    initial begin : monitor
        exp_t e;
        int   edge_n;
        edge_n = 0;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0) begin
                if (armed) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_underflow time=%0t got=empty required=entry", $time);
                end
            end else begin
                e = exp_q.pop_front();
                edge_n++;
                total++;
                if (gpi_out !== e.lvl) begin
                    bad++;
                    $display("FAIL gpi_out edge=%0d got=%b required=%b", edge_n, gpi_out, e.lvl);
                end
                total++;
                if ({gpi_rise, gpi_fall, gpi_changed} !== {e.rise, e.fall, e.chg}) begin
                    bad++;
                    $display("FAIL pulses edge=%0d got rise=%b fall=%b chg=%b required rise=%b fall=%b chg=%b",
                             edge_n, gpi_rise, gpi_fall, gpi_changed, e.rise, e.fall, e.chg);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog time=%0t got=running required=finished", $time);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [W-1:0] v;
        int           len;
        logic         r;

        drive(1'b1, 4'b0000, 3);
        // Clean single-bit rise
        drive(1'b0, 4'b0001, 14);
        // Bounce on bit1, then settle high
        drive(1'b0, 4'b0011, 3);
        drive(1'b0, 4'b0001, 3);
        drive(1'b0, 4'b0011, 3);
        drive(1'b0, 4'b0001, 3);
        drive(1'b0, 4'b0011, 14);
        drive(1'b0, 4'b0000, 14);
        // Simultaneous rise and fall on two bits
        drive(1'b0, 4'b1010, 14);
        drive(1'b0, 4'b0000, 14);
        // Reset in the middle of a pending window on bit2
        drive(1'b0, 4'b0100, 7);
        drive(1'b1, 4'b0100, 1);
        drive(1'b0, 4'b0100, 14);
        drive(1'b0, 4'b0000, 14);
        // Glitch one cycle short of the window, then exactly the window
        drive(1'b0, 4'b1000, 7);
        drive(1'b0, 4'b0000, 14);
        drive(1'b0, 4'b1000, 8);
        drive(1'b0, 4'b0000, 20);
        // Pins held high through reset
        drive(1'b0, 4'b1111, 14);
        drive(1'b1, 4'b1111, 2);
        drive(1'b0, 4'b1111, 14);
        // Random segments, lengths clustered around the window boundary
        for (int i = 0; i < 80; i++) begin
            v   = W'($urandom);
            len = (i % 2 == 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(D - 2, D + 3));
            r   = ($urandom_range(0, 39) == 0);
            drive(r, v, r ? 1 : len);
        end
        drive(1'b0, 4'b0000, 16);

        #3;
        armed = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpi_debounce.md
GPI_DEBOUNCE -- requirements
Module: gpi_debounce

Interface
REQ-001 Parameter WIDTH, default 4, number of independent input bits.
REQ-002 Parameter DEBOUNCE_CYCLES, default 480000 (10 ms at 48 MHz), stability window in clk cycles; legal range 2..2^24.
REQ-003 Port clk  input  1  system clock, 48 MHz PLL output; all logic on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port gpi_raw  input  WIDTH  asynchronous board pins (switches/buttons).
REQ-006 Port gpi_out  output  WIDTH  debounced, synchronised level; drives cpu_top gpi_in.
REQ-007 Port gpi_rise  output  WIDTH  one-cycle pulse per bit on debounced 0->1.
REQ-008 Port gpi_fall  output  WIDTH  one-cycle pulse per bit on debounced 1->0.
REQ-009 Port gpi_changed  output  1  OR of gpi_rise and gpi_fall, same cycle.

Function
REQ-010 Each bit shall pass through a two-flop synchroniser (sync1, sync2) before any other logic.
REQ-011 Each bit shall hold a stable register (drives gpi_out) and a counter of width clog2(DEBOUNCE_CYCLES).
REQ-012 Per edge, if sync2 == stable: counter <= 0, stable unchanged.
REQ-013 Per edge, if sync2 != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
REQ-014 Per edge, if sync2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync2, counter <= 0.
REQ-015 Latency: a pin level held steady shall appear on gpi_out at the (DEBOUNCE_CYCLES+2)th rising edge, counting the edge that first samples the new level as edge 1.
REQ-016 Any return of sync2 to the stable value before the window completes (bounce/glitch) shall zero the counter; no output change, no pulse.
REQ-017 gpi_rise/gpi_fall shall be registered, asserted in the cycle gpi_out shows the new value, and deasserted the following cycle.
REQ-018 Bits shall be fully independent; simultaneous transitions on several bits shall produce simultaneous pulses; gpi_changed asserts once for that cycle.
REQ-019 Counter shall never exceed DEBOUNCE_CYCLES-1; no wrap-around.

Reset
REQ-020 While rst is high on an edge: sync1, sync2, stable, counters, gpi_out, gpi_rise, gpi_fall, gpi_changed shall all become 0.
REQ-021 Reset asserted mid-window shall discard the pending count; no pulse shall be emitted for the aborted transition.
REQ-022 A pin held at 1 through reset shall reach gpi_out as 1 DEBOUNCE_CYCLES+2 edges after the first non-reset edge, with one gpi_rise pulse.

Configuration
REQ-023 Macro GPI_DEBOUNCE_EDGE_EN: defined -> edge-pulse logic of REQ-007..009, REQ-017 built.
REQ-024 Undefined -> ports gpi_rise, gpi_fall, gpi_changed remain present and shall be tied constant 0; gpi_out behaviour unchanged.

Structure
REQ-025 Shared package gpio_pkg shall hold GPI_WIDTH (4) and GPI_DEBOUNCE_DEFAULT (480000) constants; gpi_debounce defaults reference them.
REQ-026 One sub-module debounce_bit (synchroniser, counter, stable register, edge pulses for one bit) shall be instantiated WIDTH times via generate.
REQ-027 gpi_debounce shall contain only the generate loop and the gpi_changed OR reduction.

Verification (bench uses DEBOUNCE_CYCLES=8, WIDTH=4)
REQ-028 Clean edge: gpi_raw 0000->0001 held -> gpi_out[0]=1 at edge 10 after sampling edge, gpi_rise=0001 and gpi_changed=1 for exactly that cycle.
REQ-029 Bounce: bit1 toggles 1,0,1,0 every 3 cycles then holds 1 -> no output change during toggling; gpi_out[1]=1 exactly 10 edges after final rise sampled; single gpi_rise pulse.
REQ-030 Simultaneous: 0000->1010 held -> gpi_out=1010 same cycle, gpi_rise=1010, one-cycle gpi_changed; later 1010->0000 -> gpi_fall=1010.
REQ-031 Reset mid-window: bit2 rises, rst pulsed 1 cycle at count 5 -> all outputs 0 after reset edge, no pulse; bit2 output rises 10 edges after first post-reset edge.
REQ-032 Glitch rejection: 7-cycle high pulse on bit3 -> gpi_out[3] stays 0, no pulse; 8-cycle high -> gpi_out[3] rises.
REQ-033 Macro off: repeat REQ-028 -> gpi_out identical, gpi_rise/gpi_fall/gpi_changed constantly 0.
